// File: rtl/op_pkg.sv
// Shared types and constants for the operation1 dispatcher slice.
package op_pkg;

    localparam int OP_W            = 16;
    localparam int DEFAULT_TIMEOUT = 1024;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ACCEPT   = 3'd1,
        ACK      = 3'd2,
        WAIT_RES = 3'd3,
        RESP     = 3'd4
    } state_t;

endpackage

// File: rtl/op_timeout_ctr.sv
// Per-state wait counter: cleared on state entry, counts while enabled,
// flags expiry on the TIMEOUT-th enabled cycle. TIMEOUT=0 never expires.
module op_timeout_ctr
    import op_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LIMIT = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Expiry looks only at the current count so it cannot loop back through clear.
    assign expired = (TIMEOUT != 0) && enable && (count_q == LIMIT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/op1_dispatcher.sv
// Command-side master for operation1 (a*b + c*d): issues one operand packet,
// collects the result as operation1's output module and returns it to the CPU.
module op1_dispatcher
    import op_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [OP_W-1:0]  cmd_a,
    input  logic [OP_W-1:0]  cmd_b,
    input  logic [OP_W-1:0]  cmd_c,
    input  logic [OP_W-1:0]  cmd_d,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [OP_W-1:0]  resp_data,
    output logic             resp_err,
    output logic [CNT_W-1:0] done_count,
    output logic [OP_W-1:0]  input_a,
    output logic [OP_W-1:0]  input_b,
    output logic [OP_W-1:0]  input_c,
    output logic [OP_W-1:0]  input_d,
    output logic             op1_input_STB,
    input  logic             op1_BUSY,
    input  logic [OP_W-1:0]  output_result,
    input  logic             op1_output_STB,
    output logic             output_module_BUSY
);

    state_t           state_q, state_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             resp_valid_q, resp_valid_d;
    logic [OP_W-1:0]  resp_data_q, resp_data_d;
    logic             resp_err_q, resp_err_d;
    logic [CNT_W-1:0] done_q, done_d;
    logic [OP_W-1:0]  in_a_q, in_a_d;
    logic [OP_W-1:0]  in_b_q, in_b_d;
    logic [OP_W-1:0]  in_c_q, in_c_d;
    logic [OP_W-1:0]  in_d_q, in_d_d;
    logic             stb_q, stb_d;
    logic             omb_q, omb_d;

    logic tmo_clear;
    logic tmo_enable;
    logic tmo_expired;

    assign tmo_enable = (state_q == ACCEPT) || (state_q == ACK) || (state_q == WAIT_RES);
    assign tmo_clear  = (state_d != state_q);

    op_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .expired (tmo_expired)
    );

    always_comb begin
        state_d      = state_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
        done_d       = done_q;
        in_a_d       = in_a_q;
        in_b_d       = in_b_q;
        in_c_d       = in_c_q;
        in_d_d       = in_d_q;
        stb_d        = stb_q;
        omb_d        = omb_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    in_a_d  = cmd_a;
                    in_b_d  = cmd_b;
                    in_c_d  = cmd_c;
                    in_d_d  = cmd_d;
                    stb_d   = 1'b1;
                    state_d = ACCEPT;
                end
            end
            // Waiting for BUSY low first skips a stale BUSY from the previous operation.
            ACCEPT: begin
                if (!op1_BUSY) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                if (op1_BUSY) begin
                    stb_d   = 1'b0;
                    omb_d   = 1'b0;
                    state_d = WAIT_RES;
                end
            end
            WAIT_RES: begin
                if (op1_output_STB && !omb_q) begin
                    resp_data_d  = output_result;
                    resp_err_d   = 1'b0;
                    omb_d        = 1'b1;
                    resp_valid_d = 1'b1;
                    done_d       = done_q + CNT_W'(1);
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Handshake progress wins over an expiry landing on the same edge.
        if (tmo_expired && (state_d == state_q)) begin
            stb_d        = 1'b0;
            omb_d        = 1'b1;
            resp_data_d  = '0;
            resp_err_d   = 1'b1;
            resp_valid_d = 1'b1;
            state_d      = RESP;
        end

        cmd_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            cmd_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            done_q       <= '0;
            in_a_q       <= '0;
            in_b_q       <= '0;
            in_c_q       <= '0;
            in_d_q       <= '0;
            stb_q        <= 1'b0;
            omb_q        <= 1'b1;
        end else begin
            state_q      <= state_d;
            cmd_ready_q  <= cmd_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
            done_q       <= done_d;
            in_a_q       <= in_a_d;
            in_b_q       <= in_b_d;
            in_c_q       <= in_c_d;
            in_d_q       <= in_d_d;
            stb_q        <= stb_d;
            omb_q        <= omb_d;
        end
    end

    assign cmd_ready          = cmd_ready_q;
    assign resp_valid         = resp_valid_q;
    assign resp_data          = resp_data_q;
    assign resp_err           = resp_err_q;
    assign done_count         = done_q;
    assign input_a            = in_a_q;
    assign input_b            = in_b_q;
    assign input_c            = in_c_q;
    assign input_d            = in_d_q;
    assign op1_input_STB      = stb_q;
    assign output_module_BUSY = omb_q;

endmodule
